// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
// The state encoding and output decode live here so the FSM stays a plain next-state table.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StAdd,
      StShift,
      StDone
   } state_t;

   // add marks the ADD state; ALU_en/W_ctrl are gated with LSB outside the register.
   typedef struct packed {
      logic prod_load;
      logic add;
      logic srl;
      logic ready;
      logic done;
   } ctrl_t;

   function automatic int unsigned cnt_w(input int unsigned width);
      return int'($clog2(width)) + 1;
   endfunction

   function automatic ctrl_t decode(input state_t st);
      ctrl_t c;
      c = '{default: 1'b0};
      case (st)
         StIdle:  c.ready     = 1'b1;
         StLoad:  c.prod_load = 1'b1;
         StAdd:   c.add       = 1'b1;
         StShift: c.srl       = 1'b1;
         StDone: begin
            c.ready = 1'b1;
            c.done  = 1'b1;
         end
         default: c.ready     = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter: cleared on load, bumped once per shift, flags the final iteration.
module mul_iter_counter
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH,
   parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
   input  logic clk,
   input  logic Reset,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CNT_W-1:0] iter_q;

   always_ff @(posedge clk) begin
      if (Reset || clr) begin
         iter_q <= '0;
      end else if (inc) begin
         iter_q <= iter_q + CNT_W'(1);
      end
   end

   assign last = (iter_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_controller.sv
// Control FSM for the sequential shift-add multiplier: LOAD, WIDTH x (ADD, SHIFT), DONE.
// Outputs are registered from the next state; only ALU_en/W_ctrl see LSB combinationally.
module mul_controller
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH,
   parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
   input  logic clk,
   input  logic Reset,
   input  logic Run,
   input  logic LSB,
   output logic Prod_load,
   output logic ALU_en,
   output logic W_ctrl,
   output logic SRL_ctrl,
   output logic Ready,
   output logic Done
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q;
   logic   last;

   mul_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .Reset (Reset),
      .clr   (state_q == StLoad),
      .inc   (state_q == StShift),
      .last  (last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (Run) state_d = StLoad;
         StLoad:  state_d = StAdd;
         StAdd:   state_d = StShift;
         StShift: state_d = last ? StDone : StAdd;
         StDone:  state_d = Run ? StLoad : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= StIdle;
         ctrl_q  <= decode(StIdle);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
      end
   end

   assign Prod_load = ctrl_q.prod_load;
   assign ALU_en    = ctrl_q.add & LSB;
   assign W_ctrl    = ctrl_q.add & LSB;
   assign SRL_ctrl  = ctrl_q.srl;
   assign Ready     = ctrl_q.ready;
   assign Done      = ctrl_q.done;

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller: drives a behavioural Product/ALU datapath and scores every Done
// against a*b, the expected add mask (multiplier bits) and the expected Done cycle.
module tb_mul_controller;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic Reset = 1'b1;
   logic Run = 1'b0;
   logic LSB;
   logic Prod_load, ALU_en, W_ctrl, SRL_ctrl, Ready, Done;

   always #5 clk = ~clk;

   mul_controller #(.WIDTH(W)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .Run       (Run),
      .LSB       (LSB),
      .Prod_load (Prod_load),
      .ALU_en    (ALU_en),
      .W_ctrl    (W_ctrl),
      .SRL_ctrl  (SRL_ctrl),
      .Ready     (Ready),
      .Done      (Done)
   );

   // Product register and ALU around the controller.
   logic [63:0]  prod;
   logic         carry_q;
   logic [31:0]  mplier = '0;
   logic [31:0]  mcand = '0;
   logic [32:0]  alu;

   assign alu = ALU_en ? ({1'b0, prod[63:32]} + {1'b0, mcand}) : {1'b0, prod[63:32]};
   assign LSB = prod[0];

   always @(posedge clk) begin
      carry_q <= alu[32];
      if (Prod_load) prod <= {32'd0, mplier};
      else if (!Ready) begin
         if (W_ctrl) prod[63:32] <= alu[31:0];
         else if (SRL_ctrl) prod <= {carry_q, prod[63:1]};
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   typedef struct {
      logic [63:0] prod;
      logic [31:0] mask;
      int          done_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   done_cnt = 0;

   // Monitor: tracks the add pattern per run and scores each Done.
   initial begin
      logic [31:0] mask;
      int          it;
      logic        bad;
      exp_t        e;
      mask = '0; it = 0; bad = 1'b0;
      forever begin
         @(negedge clk);
         if (!Reset) begin
            if ((W_ctrl && SRL_ctrl) || (ALU_en !== W_ctrl)) bad = 1'b1;
            if (Prod_load) begin
               mask = '0; it = 0; bad = 1'b0;
            end
            if (W_ctrl && it < 32) mask[it] = 1'b1;
            if (SRL_ctrl) it++;
            if (Done) begin
               done_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("product", prod, e.prod);
                  check("add_mask", 64'(mask), 64'(e.mask));
                  check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                  check("done_ready", 64'(Ready), 64'd1);
                  check("ctrl_exclusive", 64'(bad), 64'd0);
                  check("iter_count", 64'(it), 64'(W));
               end
            end
         end
      end
   end

   function automatic logic [5:0] outs();
      return {Prod_load, ALU_en, W_ctrl, SRL_ctrl, Ready, Done};
   endfunction

   // Run sampled at edge k: DONE is entered at edge k + 2W + 1 (2W+2 edges counting edge k).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      mplier = a;
      mcand  = b;
      @(negedge clk);
      Run = 1'b1;
      @(posedge clk);
      #1;
      Run = 1'b0;
      e.prod = 64'(a) * 64'(b);
      e.mask = a;
      e.done_cyc = cyc + 2 * W + 1;
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      int n0;
      n0 = done_cnt;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != n0) return;
      end
      check("done_timeout", 64'(done_cnt), 64'(n0 + 1));
   endtask

   task automatic wait_shifts(input int n, output logic found);
      int seen;
      seen = 0;
      found = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         if (SRL_ctrl) begin
            seen++;
            if (seen == n) begin
               found = 1'b1;
               return;
            end
         end
      end
      check("shift_timeout", 64'(seen), 64'(n));
   endtask

   initial begin
      logic found;
      int   n0;
      exp_t e1, e2;

      // Reset held three cycles, then idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 64'(outs()), 64'b000010);
      Reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_hold", 64'(outs()), 64'b000010);

      start_op(32'd5, 32'd3);
      wait_done();
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      start_op(32'd0, 32'h1234_5678);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         start_op($urandom, $urandom);
         wait_done();
      end

      // Run pulsed during iteration 10 must be ignored.
      n0 = done_cnt;
      start_op($urandom, $urandom);
      wait_shifts(10, found);
      Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      wait_done();
      repeat (2 * W + 10) @(negedge clk);
      check("single_done", 64'(done_cnt - n0), 64'd1);

      // Reset during SHIFT of iteration 7 aborts the run.
      start_op($urandom, $urandom);
      wait_shifts(8, found);
      Reset = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      check("reset_mid", 64'(outs()), 64'b000010);
      Reset = 1'b0;
      @(negedge clk);
      check("reset_idle", 64'(outs()), 64'b000010);
      start_op(32'd7, 32'd9);
      wait_done();

      // Run held across DONE: LOAD follows immediately, second Done 2W+2 edges later.
      mplier = 32'd123_457;
      mcand  = 32'd99_991;
      @(negedge clk);
      Run = 1'b1;
      @(posedge clk);
      #1;
      e1.prod = 64'(mplier) * 64'(mcand);
      e1.mask = mplier;
      e1.done_cyc = cyc + 2 * W + 1;
      e2.mask = $urandom;
      e2.prod = 64'(e2.mask) * 64'(32'hDEAD_BEEF);
      e2.done_cyc = e1.done_cyc + 2 * W + 2;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      wait_done();
      mplier = e2.mask;
      mcand  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      Run = 1'b0;
      @(negedge clk);
      check("load_follows", 64'(Prod_load), 64'd1);
      wait_done();

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
